// File: rtl/enq_source_if.sv
// enq_source_if: handshake bundle between a word source and its sink.
//   enq        source -> sink  word valid this cycle
//   dout       source -> sink  word presented to the sink
//   enq_ready  sink -> source  sink accepts the word this cycle
// A word moves when enq and enq_ready are both high at a rising clock edge.
interface enq_source_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  enq;
  logic                  enq_ready;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output enq, output dout, input enq_ready);
  modport slave  (input enq, input dout, output enq_ready);
endinterface

// File: rtl/enq_source.sv
// enq_source: generates a burst of incrementing words on an enq/enq_ready
// handshake, with an optional fixed number of idle cycles after each word.
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-low reset
//   start        request a burst (sampled in IDLE only)
//   base/len/gap first word, word count, idle cycles between words
//   abort        end the current burst without a done pulse
//   bus          master side of enq_source_if (enq, dout, enq_ready)
//   busy         high while a burst is in progress (RUN or GAP)
//   done         one-cycle pulse after the last word of a normal burst
//   sent         words transferred in the current or most recent burst
module enq_source #(
  parameter int DATA_WIDTH  = 4,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  base,
  input  logic [COUNT_WIDTH-1:0] len,
  input  logic [COUNT_WIDTH-1:0] gap,
  input  logic                   abort,
  enq_source_if.master           bus,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sent
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t                 state_q,   state_d;
  logic [DATA_WIDTH-1:0]  dout_q,    dout_d;
  logic [COUNT_WIDTH-1:0] rem_q,     rem_d;
  logic [COUNT_WIDTH-1:0] gap_q,     gap_d;
  logic [COUNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [COUNT_WIDTH-1:0] sent_q,    sent_d;
  logic                   done_q,    done_d;

  // sent holds at all-ones rather than wrapping
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      dout_q    <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      sent_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      sent_q    <= sent_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    sent_d    = sent_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort outranks start: a coincident start is not accepted
        if (start && !abort) begin
          sent_d = '0;
          if (len != '0) begin
            dout_d  = base;
            rem_d   = len;
            gap_d   = gap;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (bus.enq_ready) begin
          // the transfer counts even when abort arrives in the same cycle
          sent_d = sat_inc(sent_q);
          dout_d = dout_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (abort) begin
            state_d = IDLE;
          end else if (rem_q == COUNT_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            gap_cnt_d = gap_q;
            state_d   = GAP;
          end
        end else if (abort) begin
          state_d = IDLE;
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
          if (gap_cnt_q == COUNT_WIDTH'(1)) state_d = RUN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.enq  = (state_q == RUN);
  assign bus.dout = dout_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign sent     = sent_q;

endmodule

// File: tb/tb_enq_source.sv
module tb_enq_source;

  localparam int DW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] base;
  logic [CW-1:0] len;
  logic [CW-1:0] gap;
  logic          abort;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent;

  int n_cmp = 0;
  int n_err = 0;

  enq_source_if #(.DATA_WIDTH(DW)) bus ();

  enq_source #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .base  (base),
    .len   (len),
    .gap   (gap),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .sent  (sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // check enq, dout, busy, done, sent in one go
  task automatic chk_all(input string tag, input logic e, input logic [DW-1:0] d,
                         input logic b, input logic dn, input logic [CW-1:0] s);
    chk({tag, ".enq"},  32'(bus.enq),  32'(e));
    chk({tag, ".dout"}, 32'(bus.dout), 32'(d));
    chk({tag, ".busy"}, 32'(busy),     32'(b));
    chk({tag, ".done"}, 32'(done),     32'(dn));
    chk({tag, ".sent"}, 32'(sent),     32'(s));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base = '0; len = '0; gap = '0; abort = 1'b0;
    bus.enq_ready = 1'b0;

    // reset state
    tick(); tick();
    chk_all("reset", 1'b0, 4'h0, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;

    // back-to-back burst: base 1, len 2, gap 0
    base = 4'h1; len = 4'd2; gap = 4'd0; bus.enq_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk_all("b2b.w0", 1'b1, 4'h1, 1'b1, 1'b0, 4'd0);
    tick();
    chk_all("b2b.w1", 1'b1, 4'h2, 1'b1, 1'b0, 4'd1);
    tick();
    chk("b2b.end.enq",  32'(bus.enq), 32'd0);
    chk("b2b.end.done", 32'(done),    32'd1);
    chk("b2b.end.sent", 32'(sent),    32'd2);
    tick();
    chk("b2b.done_pulse", 32'(done), 32'd0);

    // stalled burst: base 1, len 3, ready low for 3 cycles
    base = 4'h1; len = 4'd3; gap = 4'd0; bus.enq_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk_all("stall.c0", 1'b1, 4'h1, 1'b1, 1'b0, 4'd0);
    tick();
    chk_all("stall.c1", 1'b1, 4'h1, 1'b1, 1'b0, 4'd0);
    tick();
    chk_all("stall.c2", 1'b1, 4'h1, 1'b1, 1'b0, 4'd0);
    bus.enq_ready = 1'b1;
    tick();
    chk_all("stall.w1", 1'b1, 4'h2, 1'b1, 1'b0, 4'd1);
    tick();
    chk_all("stall.w2", 1'b1, 4'h3, 1'b1, 1'b0, 4'd2);
    tick();
    chk("stall.end.enq",  32'(bus.enq), 32'd0);
    chk("stall.end.done", 32'(done),    32'd1);
    chk("stall.end.sent", 32'(sent),    32'd3);
    tick();

    // gapped burst with data wrap: E, F, 0 with 2 idle cycles between words
    base = 4'hE; len = 4'd3; gap = 4'd2; start = 1'b1;
    tick(); start = 1'b0;
    chk_all("gap.w0", 1'b1, 4'hE, 1'b1, 1'b0, 4'd0);
    tick();
    chk_all("gap.g0a", 1'b0, 4'hF, 1'b1, 1'b0, 4'd1);
    tick();
    chk_all("gap.g0b", 1'b0, 4'hF, 1'b1, 1'b0, 4'd1);
    tick();
    chk_all("gap.w1", 1'b1, 4'hF, 1'b1, 1'b0, 4'd1);
    tick();
    chk_all("gap.g1a", 1'b0, 4'h0, 1'b1, 1'b0, 4'd2);
    tick();
    chk_all("gap.g1b", 1'b0, 4'h0, 1'b1, 1'b0, 4'd2);
    tick();
    chk_all("gap.w2", 1'b1, 4'h0, 1'b1, 1'b0, 4'd2);
    tick();
    chk("gap.end.enq",  32'(bus.enq), 32'd0);
    chk("gap.end.busy", 32'(busy),    32'd0);
    chk("gap.end.done", 32'(done),    32'd1);
    chk("gap.end.sent", 32'(sent),    32'd3);
    tick();

    // zero-length burst
    base = 4'h5; len = 4'd0; gap = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk_all("len0", 1'b0, 4'h1, 1'b0, 1'b1, 4'd0);
    tick();
    chk("len0.after.done", 32'(done),    32'd0);
    chk("len0.after.enq",  32'(bus.enq), 32'd0);

    // abort on the 2nd transfer; start while busy is ignored
    base = 4'h0; len = 4'd5; gap = 4'd0; start = 1'b1;
    tick();
    chk_all("abort.w0", 1'b1, 4'h0, 1'b1, 1'b0, 4'd0);
    base = 4'h9; len = 4'd1;  // start still high while busy
    tick();
    chk_all("abort.w1", 1'b1, 4'h1, 1'b1, 1'b0, 4'd1);
    start = 1'b0; abort = 1'b1;
    tick(); abort = 1'b0;
    chk_all("abort.end", 1'b0, 4'h2, 1'b0, 1'b0, 4'd2);
    tick();
    chk("abort.nodone", 32'(done), 32'd0);
    chk("abort.sent",   32'(sent), 32'd2);

    // async reset mid-burst, then a single-word burst after release
    base = 4'h3; len = 4'd4; gap = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("rst.pre.enq", 32'(bus.enq), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_all("rst.async", 1'b0, 4'h0, 1'b0, 1'b0, 4'd0);
    tick();
    rst = 1'b1;
    base = 4'h7; len = 4'd1; gap = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk_all("rst.new.w0", 1'b1, 4'h7, 1'b1, 1'b0, 4'd0);
    tick();
    chk("rst.new.enq",  32'(bus.enq), 32'd0);
    chk("rst.new.done", 32'(done),    32'd1);
    chk("rst.new.sent", 32'(sent),    32'd1);
    tick();
    chk("rst.new.pulse", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
